// File: rtl/serial_subtractor_nbits.sv
// rtl/serial_subtractor_nbits.sv - bit-serial subtractor diff = s1 - s0 - bin, LSB first (optional SUB_OVF_EN adds ovf)
module serial_subtractor_nbits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s0,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d, br_nxt;
  logic             last_bit;
`ifdef SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  // One full-subtractor cell; operands shift right so bit i is always at [0]
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt   = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
    last_bit = (cnt == LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status decode; DONE always lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      st_idle: begin
        if (start) state_nxt = st_run;
      end
      st_run: begin
        busy = 1'b1;
        if (last_bit) state_nxt = st_done;
      end
      st_done: begin
        done      = 1'b1;
        state_nxt = st_idle;
      end
      default: state_nxt = st_idle;
    endcase
  end

  // Datapath: capture on accept, one bit per RUN cycle, results land with the
  // final bit so they are already valid during the DONE cycle and held after
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        st_idle: begin
          if (start) begin
            a_sh  <= s1;
            b_sh  <= s0;
            br    <= bin;
            cnt   <= '0;
            res   <= '0;
`ifdef SUB_OVF_EN
            a_msb <= s1[WIDTH-1];
            b_msb <= s0[WIDTH-1];
`endif
          end
        end
        st_run: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          res  <= {d, res[WIDTH-1:1]};
          if (last_bit) begin
            diff <= {d, res[WIDTH-1:1]};
            bout <= br_nxt;
`ifdef SUB_OVF_EN
            ovf  <= (a_msb != b_msb) & (d != a_msb);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbits.sv
// tb/tb_serial_subtractor_nbits.sv - randomized self-checking bench for serial_subtractor_nbits
module tb_serial_subtractor_nbits;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] s1 = '0, s0 = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_total = 0;

  serial_subtractor_nbits #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s1    (s1),
    .s0    (s0),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Timeline model: phase = edges since acceptance (-1 when idle).
  int           phase = -1;
  logic [W-1:0] m_diff = '0, p_diff = '0;
  logic         m_bout = 1'b0, p_bout = 1'b0;
  logic         m_ovf = 1'b0, p_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  = -1;
      m_diff = '0;
      m_bout = 1'b0;
      m_ovf  = 1'b0;
    end else if (phase == -1) begin
      if (start) begin
        int sres;
        phase = 0;
        {p_bout, p_diff} = {1'b0, s1} - {1'b0, s0} - {{W{1'b0}}, bin};
        sres  = int'($signed(s1)) - int'($signed(s0)) - int'(bin);
        p_ovf = (sres < -(2 ** (W - 1))) || (sres > 2 ** (W - 1) - 1);
      end
    end else begin
      phase++;
      if (phase == W) begin
        m_diff = p_diff;
        m_bout = p_bout;
        m_ovf  = p_ovf;
      end
      if (phase == W + 1) phase = -1;
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      logic e_busy, e_done;
      e_busy = (phase >= 0) && (phase < W);
      e_done = (phase == W);
      checks++;
      if ({busy, done, diff, bout} !== {e_busy, e_done, m_diff, m_bout}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t busy/done/diff/bout got %b/%b/%h/%b want %b/%b/%h/%b",
                 $time, busy, done, diff, bout, e_busy, e_done, m_diff, m_bout);
      end
`ifdef SUB_OVF_EN
      checks++;
      if (ovf !== m_ovf) begin
        errors++;
        $display("FAIL ovf_cmp t=%0t got %b want %b", $time, ovf, m_ovf);
      end
`endif
      if (done === 1'b1) done_total++;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Directed op with hand-computed literals; also pins the model itself
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat;
    s1 = a; s0 = b; bin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s1 = ~a; s0 = ~b; bin = ~c;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, W + 1);
    check("diff_lit", int'(diff), int'(ed));
    check("bout_lit", int'(bout), int'(eb));
    check("model_diff_lit", int'(m_diff), int'(ed));
`ifdef SUB_OVF_EN
    check("ovf_lit", int'(ovf), int'(eo));
`else
    check("model_ovf_lit", int'(p_ovf), int'(eo));
`endif
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start held with operands churning: one result every W+2 cycles
    n = 0;
    for (int i = 0; i < 40; i++) begin
      s1 = 8'($urandom); s0 = 8'($urandom); bin = 1'($urandom); start = 1'b1;
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    start = 1'b0;
    check("held_start_dones", n, 4);
    repeat (12) @(negedge clk);

    // reset in the middle of an operation aborts it
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    s1 = 8'h20; s0 = 8'h10; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n = done_total;
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_bout", int'(bout), 0);
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_total, n);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);

    // random traffic, compare process checks every cycle
    n = done_total;
    for (int i = 0; i < 12000; i++) begin
      case ($urandom_range(0, 7))
        0:       s1 = 8'h00;
        1:       s1 = 8'hFF;
        default: s1 = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       s0 = 8'h00;
        1:       s0 = 8'hFF;
        2:       s0 = s1;
        default: s0 = 8'($urandom);
      endcase
      bin   = 1'($urandom);
      start = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_total - n < 1000) begin
      errors++;
      $display("FAIL random_ops got %0d want >=1000", done_total - n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
